// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller.
//   DEF_ADDR_W / DEF_DATA_W : default PC and instruction widths
//   DEF_PC_INC              : sequential PC step (word-addressed memory)
//   state_t                 : fetch FSM state encoding
//   pc_sel_t                : next-PC source select
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_PC_INC = 1;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PC_KEEP  = 2'd0,
        PC_SEQ   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_t;

endpackage

// File: rtl/fetch_ctrl_pc_incr.sv
// Combinational next-PC select: hold, sequential step or redirect target.
//   pc_cur    : current PC register value
//   target    : redirect target
//   sel       : source select
//   pc_next_c : selected next PC (wraps modulo 2^ADDR_W)
module pc_incr
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned PC_INC = DEF_PC_INC
) (
    input  logic [ADDR_W-1:0] pc_cur,
    input  logic [ADDR_W-1:0] target,
    input  pc_sel_t           sel,
    output logic [ADDR_W-1:0] pc_next_c
);

    always_comb begin
        pc_next_c = pc_cur;
        case (sel)
            PC_SEQ:   pc_next_c = pc_cur + ADDR_W'(PC_INC);
            PC_REDIR: pc_next_c = target;
            default:  pc_next_c = pc_cur;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: reads instruction memory at the current PC,
// presents each instruction on a valid/ready port, drives the PC register
// write port, and handles branch redirects and halt.
//   clk, rst                     : clock, synchronous active-low reset
//   pc_cur / pc_wrt / pc_next    : PC register read value and write port
//   imem_req/addr/ack/rdata      : instruction memory read handshake
//   instr_valid/ready/out/pc     : downstream instruction port
//   redirect / redirect_target   : one-cycle branch request
//   halt / halted                : stop request level / idle indication
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned PC_INC = DEF_PC_INC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_cur,
    output logic              pc_wrt,
    output logic [ADDR_W-1:0] pc_next,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt,
    output logic              halted
);

    state_t            state_q, state_d;
    logic              squash_q, squash_d;
    logic              capture_c;
    logic              req_c;
    pc_sel_t           sel_c;
    logic [ADDR_W-1:0] pc_sel_c;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= FETCH;
            squash_q    <= 1'b0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
            instr_pc    <= '0;
            halted      <= 1'b0;
        end else begin
            state_q     <= state_d;
            squash_q    <= squash_d;
            instr_valid <= (state_d == HOLD);
            halted      <= (state_d == HALT);
            if (capture_c) begin
                instr_out <= imem_rdata;
                instr_pc  <= pc_cur;
            end
        end
    end

    // Next state, squash flag and next-PC source
    always_comb begin
        state_d   = state_q;
        squash_d  = squash_q;
        capture_c = 1'b0;
        req_c     = 1'b0;
        sel_c     = PC_KEEP;
        case (state_q)
            FETCH: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    if (redirect) begin
                        // Data belongs to the old path; refetch at the target.
                        sel_c    = PC_REDIR;
                        squash_d = 1'b0;
                    end else if (squash_q) begin
                        squash_d = 1'b0;
                    end else begin
                        sel_c     = PC_SEQ;
                        capture_c = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (redirect) begin
                    // The outstanding read can't be retracted; drop its data.
                    sel_c    = PC_REDIR;
                    squash_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    sel_c   = PC_REDIR;
                    state_d = halt ? HALT : FETCH;
                end else if (instr_ready) begin
                    state_d = halt ? HALT : FETCH;
                end
            end
            HALT: begin
                if (redirect) begin
                    sel_c = PC_REDIR;
                end
                if (!halt) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    pc_incr #(
        .ADDR_W (ADDR_W),
        .PC_INC (PC_INC)
    ) u_pc_incr (
        .pc_cur    (pc_cur),
        .target    (redirect_target),
        .sel       (sel_c),
        .pc_next_c (pc_sel_c)
    );

    // PC register clears whenever pc_wrt is low, i.e. while in reset.
    assign pc_wrt    = rst;
    assign pc_next   = rst ? pc_sel_c : '0;
    assign imem_req  = rst & req_c;
    assign imem_addr = pc_cur;

endmodule
